prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Boot sequencer for the CPU. Holds the CPU in reset and receives a program image as a byte stream.
//  Assembles each pair of bytes into a 16-bit instruction and writes it into the instruction ROM.
//  After the image checksum verifies, it releases the CPU to run from pc=0.
//  Sits between the byte source (UART RX) and the ROM write port. Drives the CPU/PC reset input.
// PARAMETERS
//  ADDR_W   15  instruction ROM address width (matches pc width); max image = 2**ADDR_W words
//  TIMEOUT  0   max idle cycles between accepted bytes while loading; 0 = timeout disabled
// PORTS
//  clk        in   1       system clock; all state changes on rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       one-cycle pulse: begin (re)load; honoured only in IDLE, RUN, ERR
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data valid this cycle
//  rx_ready   out  1       loader accepts a byte; a transfer happens when rx_valid & rx_ready
//  rom_we     out  1       ROM write strobe, one cycle per word
//  rom_addr   out  ADDR_W  ROM write address (word index)
//  rom_wdata  out  16      ROM write data {hi_byte, lo_byte}
//  cpu_rst    out  1       active-high reset to CPU/PC; 1 = CPU held
//  busy       out  1       high in LEN_HI..CHK
//  done       out  1       one-cycle pulse on entry to RUN
//  err        out  1       high while in ERR
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE; cpu_rst=1; rx_ready=0; rom_we=0; rom_addr=0; rom_wdata=0; busy=0; done=0; err=0.
//  - Word index, length, checksum and timeout counters are all cleared.
//  Stream format:
//  - LEN_HI, LEN_LO: word count N, big-endian.
//  - N words, each as hi byte then lo byte.
//  - CHK: one byte = sum mod 256 of every preceding byte, including the length bytes.
//  States:
//  - IDLE   -> LEN_HI on start.
//  - LEN_HI -> LEN_LO on byte accept.
//  - LEN_LO -> on byte accept:
//      N > 2**ADDR_W -> ERR
//      N == 0        -> CHK
//      otherwise     -> DAT_HI
//  - DAT_HI -> DAT_LO on byte accept.
//  - DAT_LO -> on byte accept: DAT_HI, or CHK if this was word N-1.
//  - CHK    -> on byte accept: RUN if the byte equals the running sum, else ERR.
//  - RUN / ERR -> LEN_HI on start. Word index, sum and err are cleared, and cpu_rst=1 from the next edge.
//  Outputs by state:
//  - rx_ready = 1 exactly in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK (combinational from state).
//  - cpu_rst = 0 only in RUN.
//  - rx_valid is ignored when rx_ready=0: no accept, no sum update.
//  ROM write:
//  - On the DAT_LO accept edge: rom_wdata <= {hi, rx_data}; rom_addr <= index; rom_we <= 1 for exactly one cycle.
//  - The index increments on the same edge (registered). Back-to-back bytes give a write every 2 cycles.
//  - With N = 2**ADDR_W the final index wraps to 0. This is harmless because CHK follows.
//  Checksum:
//  - 8-bit accumulator, wraps mod 256.
//  - Updated on every accepted byte except the CHK byte.
//  Timeout (TIMEOUT>0):
//  - Counter clears on each accept and on entry to LEN_HI.
//  - Increments every cycle in a loading state without an accept.
//  - Reaching TIMEOUT -> ERR.
//  - An accept in the same cycle as the threshold wins.
//  Other rules:
//  - done pulses on the CHK->RUN edge.
//  - start is ignored in loading states.
//  - start and rx_valid together in IDLE: no byte is consumed.
//  - rst mid-load aborts immediately to IDLE. Partial ROM contents are left as is.
// TESTING
//  1. Apply reset, then stream 00 02 00 05 EC 10 03 at rx_valid=1:
//     - rom_we pulses twice: addr0=0x0005, addr1=0xEC10.
//     - done pulses once; cpu_rst falls after CHK.
//  2. Same image with checksum byte 04: ERR, err=1, cpu_rst stays 1, no done pulse.
//     Then start + correct image: RUN, err=0.
//  3. Stream 00 00 00 (N=0): RUN with no rom_we.
//     Stream 80 01 (N=0x8001, ADDR_W=15): ERR right after LEN_LO.
//  4. Insert rx_valid=0 gaps and random valid toggling: same writes as test 1.
//     Bytes presented while rx_ready=0 are never consumed.
//  5. TIMEOUT=16: stop after 3 bytes -> ERR exactly 16 cycles after the last accept.
//     A byte at cycle 15 keeps loading.
//  6. Assert rst=0 mid DAT_LO and at an asynchronous (non-edge) time:
//     - All outputs reach reset values at once.
//     - After release the state is IDLE, and a start pulse begins a fresh load.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes 16-bit words
// into the instruction ROM and releases the CPU from reset once the checksum matches.
module prog_loader #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [16:0] MAX_LEN = 17'(64'd1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t            state, state_next;
  logic [7:0]        len_hi, hi_byte, sum;
  logic [ADDR_W-1:0] idx, last_idx;
  logic [TO_W-1:0]   to_cnt;
  logic              loading, accept, timed_out;
  logic [16:0]       len_full;

  assign loading  = state inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};
  assign rx_ready = loading;
  assign accept   = rx_valid & rx_ready;
  assign len_full = {1'b0, len_hi, rx_data};
  // An accept in the threshold cycle clears the counter instead of timing out.
  assign timed_out = (TIMEOUT > 0) && loading && !accept && (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        if (len_full > MAX_LEN)  state_next = S_ERR;
        else if (len_full == '0) state_next = S_CHK;
        else                     state_next = S_DAT_HI;
      end
      S_DAT_HI: if (accept) state_next = S_DAT_LO;
      S_DAT_LO: if (accept) state_next = (idx == last_idx) ? S_CHK : S_DAT_HI;
      S_CHK:    if (accept) state_next = (rx_data == sum) ? S_RUN : S_ERR;
      S_RUN, S_ERR: if (start) state_next = S_LEN_HI;
      default:  state_next = S_IDLE;
    endcase
    if (timed_out) state_next = S_ERR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_hi    <= '0;
      hi_byte   <= '0;
      sum       <= '0;
      idx       <= '0;
      last_idx  <= '0;
      to_cnt    <= '0;
    end else begin
      state   <= state_next;
      rom_we  <= 1'b0;
      busy    <= state_next inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};
      err     <= (state_next == S_ERR);
      cpu_rst <= (state_next != S_RUN);
      done    <= (state == S_CHK) && (state_next == S_RUN);

      if (accept) to_cnt <= '0;
      else if (loading) to_cnt <= to_cnt + 1'b1;

      if (accept && state != S_CHK) sum <= sum + rx_data;

      if (accept) begin
        case (state)
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: last_idx <= ADDR_W'(len_full - 17'd1);
          S_DAT_HI: hi_byte <= rx_data;
          S_DAT_LO: begin
            rom_we    <= 1'b1;
            rom_addr  <= idx;
            rom_wdata <= {hi_byte, rx_data};
            idx       <= idx + 1'b1;
          end
          default: ;
        endcase
      end

      // Fresh load: restart word index, checksum and idle counter.
      if (state_next == S_LEN_HI && state != S_LEN_HI) begin
        idx    <= '0;
        sum    <= '0;
        to_cnt <= '0;
      end
    end
  end

endmodule
